// File: rtl/param_updown_counter_pkg.sv
// rtl/param_updown_counter_pkg.sv - shared constants for the parameterised up/down counter
// Purpose : default geometry, limit-mode encodings and a terminal-count helper.
// Ports   : none (package).
package param_updown_counter_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_MAX   = (1 << DEF_WIDTH) - 1;

   // Limit behaviour selector values for the SATURATE parameter
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // All-ones value of a w-bit counter; computed 64 bits wide so w=32 does not overflow
   function automatic logic [63:0] default_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/param_updown_counter_cnt_next.sv
// rtl/param_updown_counter_cnt_next.sv - combinational next-count and limit-event logic
// Purpose : computes the next counter value (load / step / hold) and the terminal-count flag.
// Ports   : z      - current registered count
//           up     - direction, 1 = up, 0 = down
//           en     - step enable
//           ld     - load request (wins over en)
//           d      - load value, clamped to MAX
//           z_next - value to register on the next edge
//           limit  - step in progress at a limit (terminal count)
module cnt_next
   import param_updown_counter_pkg::*;
#(
   parameter int              WIDTH    = DEF_WIDTH,
   parameter logic [WIDTH-1:0] MAX     = WIDTH'(default_max(WIDTH)),
   parameter int              SATURATE = MODE_WRAP
) (
   input  logic [WIDTH-1:0] z,
   input  logic             up,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] z_next,
   output logic             limit
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             at_max;
   logic             at_zero;
   logic [WIDTH-1:0] d_clamped;
   logic [WIDTH-1:0] up_val;
   logic [WIDTH-1:0] down_val;

   always_comb begin
      at_max    = (z == MAX);
      at_zero   = (z == '0);
      d_clamped = (d > MAX) ? MAX : d;

      // Limit values: wrap to the opposite end, or stay put when saturating
      if (at_max) begin
         up_val = (SATURATE == MODE_SAT) ? MAX : '0;
      end else begin
         up_val = z + ONE;
      end

      if (at_zero) begin
         down_val = (SATURATE == MODE_SAT) ? '0 : MAX;
      end else begin
         down_val = z - ONE;
      end

      z_next = z;
      if (ld) begin
         z_next = d_clamped;
      end else if (en) begin
         z_next = up ? up_val : down_val;
      end

      limit = en & ~ld & ((up & at_max) | (~up & at_zero));
   end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parameterised synchronous up/down counter with sticky overflow
// Purpose : registers the count and sticky overflow; next-value logic lives in cnt_next.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-high reset
//           en      - step enable
//           up      - direction, 1 = up, 0 = down
//           ld      - synchronous load of d (priority over en)
//           d       - load value
//           clr_ovf - synchronous clear of ovf (a same-edge limit event wins)
//           z       - registered count
//           tc      - combinational terminal count
//           ovf     - registered sticky wrap/saturation flag
module param_updown_counter
   import param_updown_counter_pkg::*;
#(
   parameter int              WIDTH    = DEF_WIDTH,
   parameter logic [WIDTH-1:0] MAX     = WIDTH'(default_max(WIDTH)),
   parameter int              SATURATE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] z,
   output logic             tc,
   output logic             ovf
);

   logic [WIDTH-1:0] z_q;
   logic [WIDTH-1:0] z_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             limit;

   cnt_next #(
      .WIDTH    (WIDTH),
      .MAX      (MAX),
      .SATURATE (SATURATE)
   ) u_cnt_next (
      .z      (z_q),
      .up     (up),
      .en     (en),
      .ld     (ld),
      .d      (d),
      .z_next (z_d),
      .limit  (limit)
   );

   // Set has priority over clear so a limit event is never lost
   always_comb begin
      ovf_d = ovf_q;
      if (limit) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         z_q   <= z_d;
         ovf_q <= ovf_d;
      end
   end

   assign z   = z_q;
   assign tc  = limit;
   assign ovf = ovf_q;

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width in bits (legal range 2..32).
REQ-002 Parameter MAX, default 2**WIDTH-1, SHALL set the terminal count value (legal range 1..2**WIDTH-1).
REQ-003 Parameter SATURATE, default 0, SHALL select the limit behaviour: 0 = wrap, 1 = hold at the limit.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 en  input  1  SHALL enable one count step per clock when high.
REQ-007 up  input  1  SHALL select direction: 1 = count up, 0 = count down.
REQ-008 ld  input  1  SHALL request a synchronous load of d.
REQ-009 d  input  WIDTH  SHALL be the load value.
REQ-010 clr_ovf  input  1  SHALL be a synchronous clear of the sticky overflow flag.
REQ-011 z  output  WIDTH  SHALL be the registered count value.
REQ-012 tc  output  1  SHALL be the combinational terminal-count indicator.
REQ-013 ovf  output  1  SHALL be the registered sticky wrap/saturation flag.

Function
REQ-014 Per-edge priority SHALL be: rst, then ld, then en; with none active, z SHALL hold.
REQ-015 A load SHALL set z to d on the next edge, clamped to MAX when d > MAX, regardless of en or up.
REQ-016 An up step with z < MAX SHALL set z to z+1.
REQ-017 A down step with z > 0 SHALL set z to z-1.
REQ-018 An up step at z == MAX SHALL set z to 0 when SATURATE=0, or hold MAX when SATURATE=1.
REQ-019 A down step at z == 0 SHALL set z to MAX when SATURATE=0, or hold 0 when SATURATE=1.
REQ-020 tc SHALL equal en & ~ld & ((up & z==MAX) | (~up & z==0)), i.e. high in the cycle before a limit event.
REQ-021 ovf SHALL set on every edge where a step occurs while tc is high, and SHALL remain set until clr_ovf or rst.
REQ-022 When clr_ovf and a limit event occur on the same edge, ovf SHALL be 1 (set wins).
REQ-023 Changing up while en is high SHALL take effect on the very next step, with no idle cycle.
REQ-024 The counter SHALL be fully synchronous to clk: no internal signal SHALL be used as a clock (no ripple stages).
REQ-025 All arithmetic SHALL be performed WIDTH bits wide; no intermediate value SHALL exceed MAX after clamping.

Reset
REQ-026 While rst is high, z SHALL be 0 and ovf SHALL be 0, asynchronously and independent of clk.
REQ-027 On rst deassertion, the first step SHALL occur on the first rising clk edge with en or ld high.
REQ-028 Reset asserted mid-count SHALL discard any pending load or step without a glitch to a non-zero value.

Structure
REQ-029 Default values for WIDTH and MAX, and the SATURATE encoding constants (MODE_WRAP=0, MODE_SAT=1), SHALL live in the shared counter package/include.
REQ-030 Next-value and limit logic SHALL be one combinational sub-module, cnt_next (inputs z, up, en, ld, d; outputs next value and limit event); the top SHALL hold the registers only.
REQ-031 The WIDTH=4, MAX=15, SATURATE=0, up=0, en=1 configuration SHALL reproduce the count sequence of the team's existing 4-bit down counter, without ripple delay.

Verification
REQ-032 Defaults, rst=1 then released, en=1 and up=1 for 17 clocks -> z steps 0..15 then 0; tc high when z=15; ovf=1 after the wrap.
REQ-033 WIDTH=4, MAX=9, SATURATE=0, up=0 from reset -> z steps 0, 9, 8 ... 0, 9; ovf sets on the first step.
REQ-034 SATURATE=1, MAX=9, up=1, d=7 loaded, 5 enabled clocks -> z = 8, 9, 9, 9, 9; ovf=1; then clr_ovf pulse with en=0 -> ovf=0.
REQ-035 MAX=9, ld=1 with d=12 and en=1 -> z=9 (clamped); ld=1 and en=1 together with d=3 -> z=3 (load wins).
REQ-036 z=15 with en=1, up=1, clr_ovf=1 on the same edge -> z=0 and ovf=1; then rst pulsed between clock edges -> z=0 and ovf=0 immediately.
